// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter: three result sources onto the two GPR write ports.
// Optional statistics counters are built when GPR_WB_STATS_EN is defined.
`ifndef GPR_DEPTH
`define GPR_DEPTH 5
`endif
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

module gpr_wb_arbiter #(
    parameter int AW     = `GPR_DEPTH,
    parameter int DW     = `GPR_WIDTH,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DW-1:0]     req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DW-1:0]     req1_data,
    output logic              req1_ready,
    input  logic              req2_valid,
    input  logic [AW-1:0]     req2_addr,
    input  logic [DW-1:0]     req2_data,
    output logic              req2_ready,
    output logic              wr0,
    output logic [AW-1:0]     waddr0,
    output logic [DW-1:0]     wd0,
    output logic              wr1,
    output logic [AW-1:0]     waddr1,
    output logic [DW-1:0]     wd1
`ifdef GPR_WB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    // Index 3 is a never-valid pad so a 2-bit index can never fall outside the arrays.
    logic [3:0]    valid;
    logic [AW-1:0] addr [4];
    logic [DW-1:0] data [4];

    assign valid = {1'b0, req2_valid, req1_valid, req0_valid};
    assign addr  = '{req0_addr, req1_addr, req2_addr, '0};
    assign data  = '{req0_data, req1_data, req2_data, '0};

    logic [1:0] rr_ptr;
    logic [3:0] grant;
    logic       s0_vld, s1_vld;
    logic [1:0] s0_idx, s1_idx;
    logic [1:0] last_idx;

    function automatic logic [1:0] ptr_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // NOTE: every variable gets a default before the scan so no latch is inferred, and
    // blocking assignments are used so later iterations see the slot-0 choice immediately.
    always_comb begin
        grant  = '0;
        s0_vld = 1'b0;
        s1_vld = 1'b0;
        s0_idx = '0;
        s1_idx = '0;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] idx;
            idx = ptr_add(rr_ptr, 2'(i));
            if (valid[idx]) begin
                if (!s0_vld) begin
                    s0_vld     = 1'b1;
                    s0_idx     = idx;
                    grant[idx] = 1'b1;
                end else if (!s1_vld && addr[idx] != addr[s0_idx]) begin
                    s1_vld     = 1'b1;
                    s1_idx     = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
        last_idx = s1_vld ? s1_idx : s0_idx;
    end

    // Grants are suppressed while reset is held so no source believes it transferred.
    assign req0_ready = grant[0] & rst_n;
    assign req1_ready = grant[1] & rst_n;
    assign req2_ready = grant[2] & rst_n;

    // Idle ports mirror or hold so the GPR bypass never forwards stale data.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0    <= 1'b0;
            wr1    <= 1'b0;
            waddr0 <= '0;
            waddr1 <= '0;
            wd0    <= '0;
            wd1    <= '0;
            rr_ptr <= '0;
        end else if (s0_vld) begin
            wr0    <= 1'b1;
            waddr0 <= addr[s0_idx];
            wd0    <= data[s0_idx];
            wr1    <= s1_vld;
            waddr1 <= s1_vld ? addr[s1_idx] : addr[s0_idx];
            wd1    <= s1_vld ? data[s1_idx] : data[s0_idx];
            rr_ptr <= ptr_add(last_idx, 2'd1);
        end else begin
            wr0 <= 1'b0;
            wr1 <= 1'b0;
        end
    end

`ifdef GPR_WB_STATS_EN
    logic [1:0]      n_grant;
    logic [1:0]      n_valid;
    logic [1:0]      n_stall;
    logic [STAT_W:0] wr_sum;
    logic [STAT_W:0] stall_sum;

    assign n_grant   = 2'(s0_vld) + 2'(s1_vld);
    assign n_valid   = 2'(valid[0]) + 2'(valid[1]) + 2'(valid[2]);
    assign n_stall   = n_valid - n_grant;
    assign wr_sum    = {1'b0, stat_wr_cnt} + (STAT_W + 1)'(n_grant);
    assign stall_sum = {1'b0, stat_stall_cnt} + (STAT_W + 1)'(n_stall);

    // The carry-out bit of each sum flags saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            stat_wr_cnt    <= wr_sum[STAT_W]    ? '1 : wr_sum[STAT_W-1:0];
            stat_stall_cnt <= stall_sum[STAT_W] ? '1 : stall_sum[STAT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed-vector bench for gpr_wb_arbiter; stats checks run when GPR_WB_STATS_EN is defined.
`ifndef GPR_DEPTH
`define GPR_DEPTH 5
`endif
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif

module tb_gpr_wb_arbiter;
    localparam int AW     = `GPR_DEPTH;
    localparam int DW     = `GPR_WIDTH;
    localparam int STAT_W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    vld;
    logic [AW-1:0] ad [3];
    logic [DW-1:0] dt [3];
    logic          r0, r1, r2;
    logic          wr0, wr1;
    logic [AW-1:0] waddr0, waddr1;
    logic [DW-1:0] wd0, wd1;
`ifdef GPR_WB_STATS_EN
    logic [STAT_W-1:0] stat_wr_cnt, stat_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.AW(AW), .DW(DW), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(vld[0]), .req0_addr(ad[0]), .req0_data(dt[0]), .req0_ready(r0),
        .req1_valid(vld[1]), .req1_addr(ad[1]), .req1_data(dt[1]), .req1_ready(r1),
        .req2_valid(vld[2]), .req2_addr(ad[2]), .req2_data(dt[2]), .req2_ready(r2),
        .wr0(wr0), .waddr0(waddr0), .wd0(wd0),
        .wr1(wr1), .waddr1(waddr1), .wd1(wd1)
`ifdef GPR_WB_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        vld[i] = v;
        ad[i]  = a;
        dt[i]  = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, '0, '0);
    endtask

    task automatic chk_ports(input string tag,
                             input logic e_wr0, input logic [AW-1:0] e_a0, input logic [DW-1:0] e_d0,
                             input logic e_wr1, input logic [AW-1:0] e_a1, input logic [DW-1:0] e_d1);
        chk({tag, ".wr0"},    64'(wr0),    64'(e_wr0));
        chk({tag, ".waddr0"}, 64'(waddr0), 64'(e_a0));
        chk({tag, ".wd0"},    64'(wd0),    64'(e_d0));
        chk({tag, ".wr1"},    64'(wr1),    64'(e_wr1));
        chk({tag, ".waddr1"}, 64'(waddr1), 64'(e_a1));
        chk({tag, ".wd1"},    64'(wd1),    64'(e_d1));
    endtask

    // Called at a negedge with requests already driven; returns at the next negedge.
    task automatic step(input string tag, input logic [2:0] e_rdy,
                        input logic e_wr0, input logic [AW-1:0] e_a0, input logic [DW-1:0] e_d0,
                        input logic e_wr1, input logic [AW-1:0] e_a1, input logic [DW-1:0] e_d1,
                        input logic [1:0] e_ptr);
        #1 chk({tag, ".ready"}, 64'({r2, r1, r0}), 64'(e_rdy));
        @(posedge clk);
        #1 chk_ports(tag, e_wr0, e_a0, e_d0, e_wr1, e_a1, e_d1);
        chk({tag, ".rr_ptr"}, 64'(dut.rr_ptr), 64'(e_ptr));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_all();
        set_req(0, 1'b1, 5'd2, 32'h1);
        #2 chk("rst.ready", 64'({r2, r1, r0}), 64'd0);
        chk_ports("rst", 0, 0, 0, 0, 0, 0);
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step("idle", 3'b000, 0, 0, 0, 0, 0, 0, 2'd0);

        set_req(1, 1'b1, 5'd5, 32'hA5A5A5A5);
        step("single", 3'b010, 1, 5'd5, 32'hA5A5A5A5, 0, 5'd5, 32'hA5A5A5A5, 2'd2);
        clear_all();
        step("single_idle", 3'b000, 0, 5'd5, 32'hA5A5A5A5, 0, 5'd5, 32'hA5A5A5A5, 2'd2);
        set_req(2, 1'b1, 5'd1, 32'h77);
        step("r2_alone", 3'b100, 1, 5'd1, 32'h77, 0, 5'd1, 32'h77, 2'd0);
        clear_all();

        set_req(0, 1'b1, 5'd3, 32'h11);
        set_req(1, 1'b1, 5'd4, 32'h22);
        set_req(2, 1'b1, 5'd7, 32'h33);
        step("three", 3'b011, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 2'd2);
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        step("three_tail", 3'b100, 1, 5'd7, 32'h33, 0, 5'd7, 32'h33, 2'd0);
        clear_all();

        set_req(0, 1'b1, 5'd9, 32'hAAAA0000);
        set_req(1, 1'b1, 5'd9, 32'hBBBB0000);
        step("clash", 3'b001, 1, 5'd9, 32'hAAAA0000, 0, 5'd9, 32'hAAAA0000, 2'd1);
        set_req(0, 1'b0, '0, '0);
        step("clash_2nd", 3'b010, 1, 5'd9, 32'hBBBB0000, 0, 5'd9, 32'hBBBB0000, 2'd2);
        clear_all();

        set_req(2, 1'b1, 5'd10, 32'hC2);
        set_req(0, 1'b1, 5'd10, 32'hC0);
        set_req(1, 1'b1, 5'd11, 32'hC1);
        step("clash_skip", 3'b110, 1, 5'd10, 32'hC2, 1, 5'd11, 32'hC1, 2'd2);
        set_req(1, 1'b0, '0, '0);
        set_req(2, 1'b0, '0, '0);
        step("clash_left", 3'b001, 1, 5'd10, 32'hC0, 0, 5'd10, 32'hC0, 2'd1);
        clear_all();

        set_req(1, 1'b1, 5'd6, 32'h1);
        step("byp_w1", 3'b010, 1, 5'd6, 32'h1, 0, 5'd6, 32'h1, 2'd2);
        clear_all();
        set_req(2, 1'b1, 5'd6, 32'h2);
        step("byp_w2", 3'b100, 1, 5'd6, 32'h2, 0, 5'd6, 32'h2, 2'd0);
        clear_all();
        step("byp_idle6", 3'b000, 0, 5'd6, 32'h2, 0, 5'd6, 32'h2, 2'd0);
        set_req(0, 1'b1, 5'd8, 32'h8);
        step("byp_w8", 3'b001, 1, 5'd8, 32'h8, 0, 5'd8, 32'h8, 2'd1);
        clear_all();
        step("byp_idle8", 3'b000, 0, 5'd8, 32'h8, 0, 5'd8, 32'h8, 2'd1);

        set_req(0, 1'b1, 5'd12, 32'hD0);
        set_req(1, 1'b1, 5'd13, 32'hD1);
        set_req(2, 1'b1, 5'd14, 32'hD2);
        #1 chk("midrst.pre_ready", 64'({r2, r1, r0}), 64'(3'b110));
        #2 rst_n = 1'b0;
        #1 chk("midrst.ready", 64'({r2, r1, r0}), 64'd0);
        chk_ports("midrst", 0, 0, 0, 0, 0, 0);
        chk("midrst.rr_ptr", 64'(dut.rr_ptr), 64'd0);
        @(posedge clk);
        #1 chk_ports("midrst_hold", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GPR_WB_STATS_EN
        set_req(0, 1'b1, 5'd1, 32'h101);
        set_req(1, 1'b1, 5'd2, 32'h102);
        set_req(2, 1'b1, 5'd3, 32'h103);
        repeat (100) @(posedge clk);
        #1 chk("stat_wr", 64'(stat_wr_cnt), 64'd200);
        chk("stat_stall", 64'(stat_stall_cnt), 64'd100);
        rst_n = 1'b0;
        #1 chk("stat_wr_rst", 64'(stat_wr_cnt), 64'd0);
        chk("stat_stall_rst", 64'(stat_stall_cnt), 64'd0);
        clear_all();
        @(negedge clk);
        rst_n = 1'b1;
`endif
        clear_all();
        step("final_idle", 3'b000, 0, 0, 0, 0, 0, 0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
